sm_regfile_reader: RTL and testbench

//  Debug read-out engine for the schoolRISCV register file: on a start request it walks register

---
 rtl/sm_regfile_reader_if.sv | 27 ++
 rtl/sm_regfile_reader.sv | 118 +++++++++++
 tb/tb_sm_regfile_reader.sv | 267 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/sm_regfile_reader_if.sv
// Bundles the regfile debug port, the {index,data} output stream and the scan control/status lines.
// master = reader engine, slave = regfile/sink/controller side.
interface sm_regfile_reader_if #(
    parameter int ADDR_W = 5,
    parameter int DATA_W = 32
);
    logic              start;
    logic              abort;
    logic [ADDR_W-1:0] reg_addr;
    logic [DATA_W-1:0] reg_data;
    logic              out_valid;
    logic              out_ready;
    logic [ADDR_W-1:0] out_addr;
    logic [DATA_W-1:0] out_data;
    logic              busy;
    logic              done;

    modport master (
        input  start, abort, reg_data, out_ready,
        output reg_addr, out_valid, out_addr, out_data, busy, done
    );

    modport slave (
        output start, abort, reg_data, out_ready,
        input  reg_addr, out_valid, out_addr, out_data, busy, done
    );
endinterface

// File: rtl/sm_regfile_reader.sv
// Walks regfile indices FIRST..LAST through the debug read port, streaming {index,data} words.
// Word valid 2+RD_LATENCY edges after start/handshake; one word in flight, held until out_ready.
module sm_regfile_reader #(
    parameter int ADDR_W     = 5,
    parameter int DATA_W     = 32,
    parameter int FIRST      = 0,
    parameter int LAST       = 31,
    parameter int RD_LATENCY = 0
) (
    input  logic clk,
    input  logic rst,
    sm_regfile_reader_if.master bus
);
    localparam int CNT_W = (RD_LATENCY > 1) ? $clog2(RD_LATENCY) : 1;
    localparam logic [ADDR_W-1:0] FIRST_A  = ADDR_W'(FIRST);
    localparam logic [ADDR_W-1:0] LAST_A   = ADDR_W'(LAST);
    localparam logic [CNT_W-1:0]  WAIT_END = CNT_W'((RD_LATENCY > 0) ? RD_LATENCY - 1 : 0);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, HOLD} state_t;

    state_t            state, state_nxt;
    logic [ADDR_W-1:0] idx, idx_nxt;
    logic [CNT_W-1:0]  wait_cnt, wait_cnt_nxt;
    logic              out_valid_q, out_valid_nxt;
    logic [ADDR_W-1:0] out_addr_q, out_addr_nxt;
    logic [DATA_W-1:0] out_data_q, out_data_nxt;
    logic              done_q, done_nxt;
    logic              busy_q;
    logic              capture;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state       <= IDLE;
            idx         <= FIRST_A;
            wait_cnt    <= '0;
            out_valid_q <= 1'b0;
            out_addr_q  <= '0;
            out_data_q  <= '0;
            done_q      <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state       <= state_nxt;
            idx         <= idx_nxt;
            wait_cnt    <= wait_cnt_nxt;
            out_valid_q <= out_valid_nxt;
            out_addr_q  <= out_addr_nxt;
            out_data_q  <= out_data_nxt;
            done_q      <= done_nxt;
            busy_q      <= (state_nxt != IDLE);
        end
    end

    always_comb begin
        state_nxt     = state;
        idx_nxt       = idx;
        wait_cnt_nxt  = wait_cnt;
        out_valid_nxt = out_valid_q;
        out_addr_nxt  = out_addr_q;
        out_data_nxt  = out_data_q;
        done_nxt      = 1'b0;
        capture       = 1'b0;

        // abort beats everything, including a handshake in the same cycle
        if (state != IDLE && bus.abort) begin
            state_nxt     = IDLE;
            idx_nxt       = FIRST_A;
            wait_cnt_nxt  = '0;
            out_valid_nxt = 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.start && !bus.abort) begin
                        state_nxt    = ISSUE;
                        idx_nxt      = FIRST_A;
                        wait_cnt_nxt = '0;
                    end
                end
                ISSUE: begin
                    if (RD_LATENCY == 0) capture   = 1'b1;
                    else                 state_nxt = WAIT;
                end
                WAIT: begin
                    if (wait_cnt == WAIT_END) capture      = 1'b1;
                    else                      wait_cnt_nxt = wait_cnt + 1'b1;
                end
                HOLD: begin
                    if (out_valid_q && bus.out_ready) begin
                        out_valid_nxt = 1'b0;
                        if (idx == LAST_A) begin
                            done_nxt  = 1'b1;
                            state_nxt = IDLE;
                        end else begin
                            idx_nxt      = idx + 1'b1;
                            wait_cnt_nxt = '0;
                            state_nxt    = ISSUE;
                        end
                    end
                end
                default: state_nxt = IDLE;
            endcase
        end

        if (capture) begin
            out_data_nxt  = bus.reg_data;
            out_addr_nxt  = idx;
            out_valid_nxt = 1'b1;
            state_nxt     = HOLD;
        end
    end

    // the debug address is the scan index itself, so it is registered by construction
    assign bus.reg_addr  = idx;
    assign bus.out_valid = out_valid_q;
    assign bus.out_addr  = out_addr_q;
    assign bus.out_data  = out_data_q;
    assign bus.busy      = busy_q;
    assign bus.done      = done_q;
endmodule

// File: tb/tb_sm_regfile_reader.sv
// Bench: combinational-port reader (0..31) checked by a scan-level model, plus a latency-2 reader (3..5).
module tb_sm_regfile_reader;
    logic clk;
    logic rst;

    int tests = 0;
    int fails = 0;

    logic [31:0] regs [0:31];

    sm_regfile_reader_if #(.ADDR_W(5), .DATA_W(32)) ifa ();
    sm_regfile_reader_if #(.ADDR_W(5), .DATA_W(32)) ifb ();

    sm_regfile_reader #(.ADDR_W(5), .DATA_W(32), .FIRST(0), .LAST(31), .RD_LATENCY(0))
        dut_a (.clk(clk), .rst(rst), .bus(ifa));
    sm_regfile_reader #(.ADDR_W(5), .DATA_W(32), .FIRST(3), .LAST(5), .RD_LATENCY(2))
        dut_b (.clk(clk), .rst(rst), .bus(ifb));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // register file models: x0 reads as zero; port B delays the address by two cycles
    logic [4:0] b_a1, b_a2;
    always @(posedge clk) begin
        b_a1 <= ifb.reg_addr;
        b_a2 <= b_a1;
    end
    assign ifa.reg_data = (ifa.reg_addr == 5'd0) ? 32'd0 : regs[ifa.reg_addr];
    assign ifb.reg_data = (b_a2 == 5'd0) ? 32'd0 : regs[b_a2];

    function automatic void check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // scan-level reference model for reader A, evaluated between edges on stable inputs
    int          exp_idx = 0;
    bit          m_busy = 0;
    bit          done_due = 0;
    bit          stall_prev = 0;
    logic [4:0]  prev_addr;
    logic [31:0] prev_data;
    int          acc_words = 0;
    int          done_cnt = 0;

    always @(negedge clk) begin
        if (!rst) begin
            m_busy     = 0;
            done_due   = 0;
            stall_prev = 0;
        end else begin
            check("busy", 64'(ifa.busy), 64'(m_busy));
            check("done", 64'(ifa.done), 64'(done_due));
            if (ifa.done) begin
                done_cnt++;
                check("done_valid_excl", 64'(ifa.out_valid), 64'd0);
            end
            if (!m_busy) check("idle_valid", 64'(ifa.out_valid), 64'd0);
            if (stall_prev) begin
                check("hold_valid", 64'(ifa.out_valid), 64'd1);
                check("hold_addr", 64'(ifa.out_addr), 64'(prev_addr));
                check("hold_data", 64'(ifa.out_data), 64'(prev_data));
            end
            stall_prev = 0;
            done_due   = 0;
            if (!m_busy) begin
                if (ifa.start && !ifa.abort) begin
                    m_busy  = 1;
                    exp_idx = 0;
                end
            end else if (ifa.abort) begin
                m_busy = 0;
            end else if (ifa.out_valid && ifa.out_ready) begin
                check("word_addr", 64'(ifa.out_addr), 64'(exp_idx));
                check("word_data", 64'(ifa.out_data), 64'((exp_idx == 0) ? 32'd0 : regs[exp_idx]));
                acc_words++;
                if (exp_idx == 31) begin
                    m_busy   = 0;
                    done_due = 1;
                end else begin
                    exp_idx++;
                end
            end else if (ifa.out_valid) begin
                stall_prev = 1;
                prev_addr  = ifa.out_addr;
                prev_data  = ifa.out_data;
            end
        end
    end

    typedef struct packed {
        int stall_idx;
        int stall_len;
        int abort_idx;
        int restart_idx;
        int exp_words;
        int exp_done;
    } vec_t;

    vec_t tbl [5];

    task automatic run_case(input int n, input vec_t v);
        int w0, d0, stall;
        bit fin;
        w0 = acc_words; d0 = done_cnt; stall = 0; fin = 0;
        ifa.out_ready = 1; ifa.start = 1;
        tick();
        ifa.start = 0;
        for (int c = 0; c < 400 && !fin; c++) begin
            ifa.out_ready = 1; ifa.abort = 0; ifa.start = 0;
            if (ifa.out_valid) begin
                if (int'(ifa.out_addr) == v.stall_idx && stall < v.stall_len) begin
                    ifa.out_ready = 0;
                    stall++;
                end
                if (int'(ifa.out_addr) == v.abort_idx)   ifa.abort = 1;
                if (int'(ifa.out_addr) == v.restart_idx) ifa.start = 1;
            end
            tick();
            if (!ifa.busy) fin = 1;
        end
        ifa.abort = 0; ifa.start = 0;
        tick();
        check($sformatf("case%0d_finished", n), 64'(fin), 64'd1);
        check($sformatf("case%0d_words", n), 64'(acc_words - w0), 64'(v.exp_words));
        check($sformatf("case%0d_dones", n), 64'(done_cnt - d0), 64'(v.exp_done));
    endtask

    initial begin
        int nw, nd, first_k, last_k, gap_bad, done_k, d0;
        bit fin;

        //           stall  len  abort restart words done
        tbl[0] = '{-1,    0,   -1,   -1,     32,   1};
        tbl[1] = '{ 7,    10,  -1,   -1,     32,   1};
        tbl[2] = '{-1,    0,   12,   -1,     12,   0};
        tbl[3] = '{-1,    0,   -1,    5,     32,   1};
        tbl[4] = '{ 3,    4,   20,   10,     20,   0};

        for (int i = 0; i < 32; i++) regs[i] = 32'h100 + i;
        ifa.start = 0; ifa.abort = 0; ifa.out_ready = 0;
        ifb.start = 0; ifb.abort = 0; ifb.out_ready = 0;
        rst = 0;
        repeat (3) tick();

        check("rst_a_valid", 64'(ifa.out_valid), 64'd0);
        check("rst_a_addr", 64'(ifa.out_addr), 64'd0);
        check("rst_a_data", 64'(ifa.out_data), 64'd0);
        check("rst_a_busy", 64'(ifa.busy), 64'd0);
        check("rst_a_done", 64'(ifa.done), 64'd0);
        check("rst_a_reg_addr", 64'(ifa.reg_addr), 64'd0);
        check("rst_b_reg_addr", 64'(ifb.reg_addr), 64'd3);
        rst = 1;
        tick();

        // full scan with a sink that is always ready
        ifa.out_ready = 1; ifa.start = 1;
        tick();
        ifa.start = 0;
        first_k = -1; last_k = -1; nw = 0; gap_bad = 0; done_k = -1; nd = 0;
        for (int k = 1; k <= 80; k++) begin
            tick();
            if (ifa.out_valid) begin
                if (first_k < 0) first_k = k;
                else if (k - last_k != 2) gap_bad++;
                last_k = k;
                nw++;
            end
            if (ifa.done) begin
                nd++;
                done_k = k;
                check("t1_busy_in_done", 64'(ifa.busy), 64'd0);
            end
        end
        check("t1_words", 64'(nw), 64'd32);
        check("t1_first_valid", 64'(first_k), 64'd1);
        check("t1_last_valid", 64'(last_k), 64'd63);
        check("t1_spacing", 64'(gap_bad), 64'd0);
        check("t1_done_count", 64'(nd), 64'd1);
        check("t1_done_cycle", 64'(done_k), 64'd64);
        check("t1_idle_after", 64'(ifa.busy), 64'd0);

        // latency-2 port, restricted window 3..5
        ifb.out_ready = 1; ifb.start = 1;
        tick();
        ifb.start = 0;
        nw = 0; nd = 0; first_k = -1;
        for (int k = 1; k <= 30; k++) begin
            tick();
            if (ifb.out_valid) begin
                if (first_k < 0) first_k = k;
                if (nw < 3) begin
                    check("b_addr", 64'(ifb.out_addr), 64'(3 + nw));
                    check("b_data", 64'(ifb.out_data), 64'(32'h103 + nw));
                end
                nw++;
            end
            if (ifb.done) nd++;
        end
        check("b_first_valid", 64'(first_k), 64'd3);
        check("b_words", 64'(nw), 64'd3);
        check("b_done_count", 64'(nd), 64'd1);
        check("b_idle_after", 64'(ifb.busy), 64'd0);

        for (int i = 0; i < 5; i++) run_case(i, tbl[i]);

        // start together with abort while idle must not begin a scan
        ifa.start = 1; ifa.abort = 1;
        tick();
        ifa.start = 0; ifa.abort = 0;
        check("sa_busy", 64'(ifa.busy), 64'd0);
        tick();
        check("sa_valid", 64'(ifa.out_valid), 64'd0);

        // asynchronous reset while word 20 is on the bus
        d0 = done_cnt;
        ifa.out_ready = 1; ifa.start = 1;
        tick();
        ifa.start = 0;
        for (int c = 0; c < 200 && !(ifa.out_valid && ifa.out_addr == 5'd20); c++) tick();
        check("rst_mid_reached", 64'(ifa.out_valid && ifa.out_addr == 5'd20), 64'd1);
        #2 rst = 0;
        #1;
        check("rst_mid_valid", 64'(ifa.out_valid), 64'd0);
        check("rst_mid_addr", 64'(ifa.out_addr), 64'd0);
        check("rst_mid_data", 64'(ifa.out_data), 64'd0);
        check("rst_mid_busy", 64'(ifa.busy), 64'd0);
        check("rst_mid_reg_addr", 64'(ifa.reg_addr), 64'd0);
        tick();
        tick();
        rst = 1;
        tick();
        tick();
        check("rst_mid_no_done", 64'(done_cnt - d0), 64'd0);

        // randomized sink stalls, stray starts and occasional aborts
        for (int s = 0; s < 30; s++) begin
            for (int i = 0; i < 32; i++) regs[i] = $urandom;
            ifa.start = 1;
            tick();
            ifa.start = 0;
            fin = 0;
            for (int c = 0; c < 600 && !fin; c++) begin
                ifa.out_ready = ($urandom_range(0, 3) != 0);
                ifa.abort     = ($urandom_range(0, 299) == 0);
                ifa.start     = ($urandom_range(0, 19) == 0);
                tick();
                if (!ifa.busy) fin = 1;
            end
            ifa.abort = 0; ifa.start = 0;
            tick();
            tick();
            check("rnd_finished", 64'(fin), 64'd1);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
